// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - command FIFO plus issue/capture FSM in front of the 2-bit arithmetic unit
// Define ALU_CHECK_EN to build the result reference model that drives the sticky err flag.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_data,
  output logic [1:0]       alu_a,
  output logic [1:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [2:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [5:0]       res_data,
  output logic             busy,
  output logic [CNT_W-1:0] res_count,
  output logic             err
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [6:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q;
  logic [1:0]       a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic             rv_q, rv_d;
  logic [5:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop, empty;

  // cmd_ready looks only at registered occupancy, never at the result side.
  assign empty     = (occ_q == '0);
  assign cmd_ready = (occ_q != OW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_d    = {sel_q, alu_out};
        rv_d    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          rv_d  = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) {sel_d, a_d, b_d} = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;
  assign res_count = cnt_q;
  assign busy      = !empty || (state_q != IDLE);

`ifdef ALU_CHECK_EN
  logic [2:0] exp_out;
  logic       err_q;

  always_comb begin
    exp_out = 3'd0;
    case (sel_q)
      3'd0: exp_out = {1'b0, a_q};
      3'd1: exp_out = {1'b0, a_q} + {1'b0, b_q};
      3'd2: exp_out = {1'b0, b_q} - 3'd1;
      3'd3: exp_out = (a_q > b_q) ? {1'b0, a_q - b_q} : {1'b0, b_q - a_q};
      3'd4: exp_out = {b_q, 1'b0};
      3'd5: exp_out = {2'b00, a_q[1]};
      3'd6: exp_out = {1'b0, a_q} + 3'd1;
      3'd7: exp_out = {1'b0, b_q};
      default: exp_out = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err_q <= 1'b0;
    else if (state_q == ISSUE && alu_out != exp_out) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard and vector-table bench for alu_cmd_issuer
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [6:0]       cmd_data = '0;
  logic [1:0]       alu_a, alu_b;
  logic [2:0]       alu_sel;
  logic [2:0]       alu_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [5:0]       res_data;
  logic             busy;
  logic [CNT_W-1:0] res_count;
  logic             err;
  logic             bad = 1'b0;

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  logic [5:0] sb[$];
  int         hs_cyc[$];
  logic       prev_stall = 1'b0;
  logic [5:0] prev_data = '0;

  typedef struct {
    logic [2:0] sel;
    logic [1:0] a;
    logic [1:0] b;
    logic [5:0] exp;
  } vec_t;
  vec_t vt[8];

  alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .res_count(res_count), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [2:0] alu_model(input logic [2:0] s, input logic [1:0] a, input logic [1:0] b);
    int ai = a;
    int bi = b;
    case (s)
      3'd0: return 3'(ai);
      3'd1: return 3'(ai + bi);
      3'd2: return 3'((bi + 7) % 8);
      3'd3: return 3'((ai > bi) ? ai - bi : bi - ai);
      3'd4: return 3'(bi * 2);
      3'd5: return 3'(ai / 2);
      3'd6: return 3'(ai + 1);
      default: return 3'(bi);
    endcase
  endfunction

  assign alu_out = (bad && alu_sel == 3'd6 && alu_a == 2'd1) ? 3'd0 : alu_model(alu_sel, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data", 32'(res_data), 32'(prev_data));
      end
      if (res_valid && res_ready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL stale_result: got %0h, expected no result", res_data);
        end else begin
          check("res_data", 32'(res_data), 32'(sb.pop_front()));
        end
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [2:0] s, input logic [1:0] a, input logic [1:0] b, input logic [5:0] exp);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_data  = {s, a, b};
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_mis++;
      $display("FAIL push_timeout: got cmd_ready 0, expected 1");
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb.size() == 0 && !busy), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int t;
    for (int i = 0; i < 8; i++) begin
      vt[i].sel = 3'(i);
      vt[i].a   = 2'd2;
      vt[i].b   = 2'd1;
    end
    vt[0].exp = {3'd0, 3'd2}; vt[1].exp = {3'd1, 3'd3};
    vt[2].exp = {3'd2, 3'd0}; vt[3].exp = {3'd3, 3'd1};
    vt[4].exp = {3'd4, 3'd2}; vt[5].exp = {3'd5, 3'd1};
    vt[6].exp = {3'd6, 3'd3}; vt[7].exp = {3'd7, 3'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(res_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    @(posedge clk);
    #1;

    // Latency: accept at N, res_valid visible only after N+2.
    push(3'd1, 2'd3, 2'd2, {3'd1, 3'd5});
    @(negedge clk); check("lat_n0", 32'(res_valid), 32'd0);
    @(negedge clk); check("lat_n1", 32'(res_valid), 32'd0);
    @(negedge clk); check("lat_n2", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("lat_count", 32'(res_count), 32'd1);
    check("lat_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    push(3'd2, 2'd1, 2'd0, {3'd2, 3'd7});
    wait_drain();
    check("bm1_err", 32'(err), 32'd0);

    hs_cyc.delete();
    for (int i = 0; i < 8; i++) push(vt[i].sel, vt[i].a, vt[i].b, vt[i].exp);
    wait_drain();
    check("tp_count", 32'(hs_cyc.size()), 32'd8);
    for (int i = 1; i < 8 && i < hs_cyc.size(); i++)
      check("tp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

    // Fill: one in HOLD plus DEPTH buffered, then the next command is refused.
    res_ready = 1'b0;
    base = res_count;
    for (int i = 0; i < 5; i++) begin
      logic [2:0] s = 3'(i + 3);
      logic [1:0] a = 2'(i);
      logic [1:0] b = 2'(3 - i);
      push(s, a, b, {s, alu_model(s, a, b)});
    end
    cmd_valid = 1'b1;
    cmd_data  = 7'h7f;
    @(negedge clk); check("full_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("full_ready_hold", 32'(cmd_ready), 32'd0);
    check("full_sb", 32'(sb.size()), 32'd5);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain();
    check("full_count", 32'(res_count), 32'(8'(base + 5)));

    // Reset while holding a result with three commands buffered.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(3'd1, 2'(i), 2'd1, {3'd1, alu_model(3'd1, 2'(i), 2'd1)});
    t = 0;
    while (!res_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst_hold_reached", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_res_data", 32'(res_data), 32'd0);
    check("arst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    check("arst_count", 32'(res_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_err", 32'(err), 32'd0);
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_valid", 32'(res_valid), 32'd0);
    check("post_rst_count", 32'(res_count), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

`ifdef ALU_CHECK_EN
    bad = 1'b1;
    push(3'd6, 2'd1, 2'd0, {3'd6, 3'd0});
    wait_drain();
    check("err_set", 32'(err), 32'd1);
    push(3'd1, 2'd1, 2'd1, {3'd1, 3'd2});
    wait_drain();
    check("err_sticky", 32'(err), 32'd1);
    bad = 1'b0;
`else
    push(3'd6, 2'd1, 2'd0, {3'd6, 3'd2});
    wait_drain();
    check("err_tied", 32'(err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential front-end for the 2-bit arithmetic unit: accepts packed ALU commands over a valid/ready interface, buffers them in a small FIFO, and drives `a`/`b`/`sel` onto the unit one command at a time. It captures the unit's 3-bit result and returns it, tagged with its opcode, over a second valid/ready interface. It sits between the command source (test sequencer or control logic) and the combinational arithmetic unit, and is the block that issues to it and collects from it.

## Interface

Parameters:
- `DEPTH`, 4, command FIFO entries; power of two, 2..16.
- `CNT_W`, 8, width of the delivered-result counter.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: FIFO can accept; equals not-full.
- `cmd_data`, input, 7: `{sel[2:0], a[1:0], b[1:0]}`.
- `alu_a`, output, 2: registered operand a to the arithmetic unit.
- `alu_b`, output, 2: registered operand b to the arithmetic unit.
- `alu_sel`, output, 3: registered opcode to the arithmetic unit.
- `alu_out`, input, 3: combinational result from the arithmetic unit, taken as raw bits.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts result.
- `res_data`, output, 6: `{sel[2:0], out[2:0]}`.
- `busy`, output, 1: high when the FIFO is non-empty or the FSM is not IDLE.
- `res_count`, output, CNT_W: results delivered; wraps modulo 2^CNT_W.
- `err`, output, 1: sticky result-mismatch flag (see Configuration).

## Operation

- FIFO push: on `cmd_valid && cmd_ready`. There is no bypass; a push into an empty FIFO becomes poppable the next cycle.
- FIFO pointers wrap modulo DEPTH. An occupancy count of 0..DEPTH drives full/empty.
- FSM states, with transitions:
  - IDLE:
    - FIFO non-empty: pop head into `alu_a`/`alu_b`/`alu_sel`, go to ISSUE.
  - ISSUE: one cycle for the arithmetic unit to settle.
    - Register `{alu_sel, alu_out}` into `res_data`, set `res_valid`, go to HOLD.
  - HOLD: `res_valid` high; `res_data` stable.
    - `res_ready` low: stay in HOLD.
    - `res_ready` high: clear `res_valid`, increment `res_count`.
      - FIFO non-empty: pop the next command in the same edge, go to ISSUE.
      - FIFO empty: go to IDLE.
- Simultaneous push and pop in one cycle is legal. Occupancy is unchanged, and `cmd_ready` is evaluated on pre-edge occupancy.
- `alu_a`/`alu_b`/`alu_sel` hold their last issued values in IDLE and HOLD.
- Reset (asynchronous, at any time, including mid-command):
  - FIFO emptied, FSM to IDLE.
  - `alu_a`/`alu_b`/`alu_sel` = 0, `res_valid` = 0, `res_data` = 0, `res_count` = 0, `err` = 0, `busy` = 0.
  - `cmd_ready` = 1 (empty FIFO).
  - In-flight and buffered commands are discarded.

## Timing

- Latency, command accepted at edge N with FSM idle and FIFO empty:
  - Pop at edge N+1.
  - Capture at edge N+2.
  - `res_valid` high in the cycle after edge N+2.
- Throughput: one result per 2 cycles with `res_ready` held high.
- `res_valid` and `res_data` do not change while `res_valid && !res_ready`.
- `cmd_ready` depends only on registered occupancy; it has no combinational path from `res_ready`.

## Configuration

- `ALU_CHECK_EN` defined:
  - An internal reference model computes the expected 3-bit result from the issued `alu_a`/`alu_b`/`alu_sel`:
    - 0: a
    - 1: a+b
    - 2: b-1 mod 8
    - 3: |a-b|
    - 4: b*2
    - 5: a>>1
    - 6: a+1
    - 7: b
  - The check runs at the ISSUE capture edge. If `alu_out` differs from the expected value, `err` is set and stays set until reset.
- `ALU_CHECK_EN` not defined: no model is built and `err` is tied to 0.

## Test plan

- Reset then push `{3'b001,2'd3,2'd2}` -> `res_valid` high 3 cycles after acceptance, `res_data={3'b001,3'd5}`, `res_count`=1, `busy` low after handshake.
- Push `{3'b010,2'd1,2'd0}` (b-1 with b=0) -> `res_data={3'b010,3'b111}`; with `ALU_CHECK_EN`, `err` stays 0.
- Hold `res_ready` low; push 5 commands with DEPTH=4 -> `cmd_ready` drops after the FIFO fills (4 buffered plus 1 in HOLD, one command refused); release `res_ready` -> all accepted results drain in order, `res_count` advances by one per handshake.
- `res_ready` tied high, 8 back-to-back commands (sel 0..7, a=2, b=1) -> results 2,3,0,1,2,1,3,1 at a 2-cycle spacing.
- Assert `rst_n` low while in HOLD with 3 commands buffered -> all outputs immediately at reset values, `cmd_ready`=1; after release, no stale result appears.
- `ALU_CHECK_EN` defined, bench forces `alu_out`=3'd0 for sel=6, a=1 -> `err` goes high at the capture edge and stays high through later correct results.
